pipelined_adder_tree: RTL
=========================

PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

Interface
REQ-001 Parameter ACC_BW, default 32, is the bit width of each input operand and of out_data.
REQ-002 Parameter RADIX, default 4, is the number of operands summed per node; it SHALL be a power of two, 2 or greater.
REQ-003 Parameter LEVELS, default 3, is the tree depth; N_IN = RADIX**LEVELS (default 64) is derived and SHALL NOT be set independently.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active low.
REQ-006 in_data  input  N_IN x ACC_BW  unpacked array of unsigned operands.
REQ-007 in_valid  input  1  in_data and in_mode are valid this cycle.
REQ-008 in_mode  input  1  0 = average (scaled) result, 1 = full saturated sum.
REQ-009 in_ready  output  1  block accepts a vector this cycle.
REQ-010 out_data  output  ACC_BW  final result.
REQ-011 out_ovf  output  1  saturation occurred on the current result (mode 1 only).
REQ-012 out_valid  output  1  out_data/out_ovf are valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 busy  output  1  any pipeline stage holds a valid vector.

Function
REQ-015 The tree SHALL have LEVELS registered stages; stage k (1..LEVELS) sums RADIX stage-(k-1) values per node.
REQ-016 Stage k SHALL hold full precision: ACC_BW + k*log2(RADIX) bits per node; no truncation inside the tree.
REQ-017 Each stage SHALL carry a valid bit and the mode bit of its vector alongside the data.
REQ-018 Advance condition: adv = ~out_valid | out_ready; when adv=1 every stage loads from its predecessor (valid, mode, data); when adv=0 every stage holds.
REQ-019 in_ready SHALL equal adv combinationally; a vector is accepted iff in_valid & in_ready.
REQ-020 When adv=1 and in_valid=0, stage 1 SHALL load valid=0 (bubble); bubbles are not collapsed.
REQ-021 Latency SHALL be exactly LEVELS cycles from acceptance to out_valid with no stalls; throughput one vector per cycle when out_ready=1.
REQ-022 Mode 0: out_data SHALL be final sum bits [ACC_BW+LEVELS*log2(RADIX)-1 : LEVELS*log2(RADIX)] (floor of mean); out_ovf=0.
REQ-023 Mode 1: out_data SHALL be the final sum if it is below 2**ACC_BW, else all ones with out_ovf=1; otherwise out_ovf=0.
REQ-024 out_data/out_ovf SHALL be derived combinationally from the last stage register; out_valid SHALL equal the last stage valid bit.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_ovf and out_valid SHALL remain stable.
REQ-026 busy SHALL be the OR of all stage valid bits.
REQ-027 Mode switches between consecutive vectors SHALL take effect per vector with no bubble.

Reset
REQ-028 rst_n low SHALL immediately clear all stage data, valid and mode bits to 0, regardless of clk.
REQ-029 During and after reset until first acceptance: out_valid=0, out_data=0, out_ovf=0, busy=0, in_ready=1.
REQ-030 Vectors in flight at reset assertion SHALL be discarded; none appears at the output after release.

Verification
REQ-031 All 64 inputs = 1, mode 0, out_ready=1 -> 3 cycles later out_valid=1, out_data=1, out_ovf=0; mode 1 -> out_data=64.
REQ-032 All inputs = 0xFFFFFFFF, mode 1 -> out_data=0xFFFFFFFF, out_ovf=1; same vector mode 0 -> out_data=0xFFFFFFFF, out_ovf=0.
REQ-033 Input i = i (0..63), mode 1 -> out_data=2016; mode 0 -> out_data=31.
REQ-034 Five back-to-back vectors, out_ready held 0 from the cycle the first result appears for 4 cycles -> in_ready=0 during stall, outputs stable, then all five results emerge in order with none lost or duplicated.
REQ-035 Assert rst_n low with 3 vectors in flight -> outputs and busy go 0 asynchronously; after release no stale result appears.
REQ-036 Parameter sweep RADIX=2 LEVELS=4 (N_IN=16), all inputs 5, mode 0 -> out_data=5 after 4 cycles; mode 1 -> 80.

Source files
------------

// File: rtl/pipelined_adder_tree_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_tree_if
// Purpose  : Input-vector and result handshake bundle for pipelined_adder_tree.
//            The master side supplies operand vectors and consumes results.
//            The slave side is the adder tree.
// Revision : 1.0  initial release
// ============================================================================
interface pipelined_adder_tree_if #(
  parameter int ACC_BW = 32,
  parameter int N_IN   = 64
);
  logic [ACC_BW-1:0] in_data [N_IN];
  logic              in_valid;
  logic              in_mode;
  logic              in_ready;
  logic [ACC_BW-1:0] out_data;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    output in_data, in_valid, in_mode, out_ready,
    input  in_ready, out_data, out_ovf, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, in_mode, out_ready,
    output in_ready, out_data, out_ovf, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_tree
// Purpose  : RADIX-ary adder tree, LEVELS registered stages deep, summing
//            RADIX**LEVELS unsigned operands at full precision. The result
//            is either the floor of the mean (mode 0) or the saturated sum
//            (mode 1). The whole pipeline advances in lock step whenever
//            the output slot is empty or being drained.
// Revision : 1.0  initial release
// ============================================================================
module pipelined_adder_tree #(
  parameter int ACC_BW = 32,
  parameter int RADIX  = 4,   // power of two, >= 2
  parameter int LEVELS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_adder_tree_if.slave  bus     // instantiated with N_IN = RADIX**LEVELS
);

  localparam int N_IN  = RADIX ** LEVELS;
  localparam int LOG2R = $clog2(RADIX);
  localparam int SHIFT = LEVELS * LOG2R;
  localparam int WF    = ACC_BW + SHIFT;

  logic              adv;
  logic [LEVELS:1]   vld_vec;
  logic [WF-1:0]     final_sum;
  logic [ACC_BW-1:0] res_data;
  logic              res_ovf;

  // A single global enable: bubbles are kept, so every stage moves together.
  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.busy     = |vld_vec;

  // Stage 0 is the input vector itself. Stage k holds the partial sums of
  // RADIX**k operands, widened by LOG2R bits per level so nothing is lost.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_stage
    localparam int W     = ACC_BW + k * LOG2R;
    localparam int NODES = N_IN / (RADIX ** k);

    logic [W-1:0] stg_data [NODES];
    logic         stg_vld;
    logic         stg_mode;

    if (k == 0) begin : g_src
      for (genvar n = 0; n < NODES; n++) begin : g_in
        assign stg_data[n] = bus.in_data[n];
      end
      assign stg_vld  = bus.in_valid;
      assign stg_mode = bus.in_mode;
    end else begin : g_reg
      logic [W-1:0] sum_d  [NODES];
      logic [W-1:0] data_q [NODES];
      logic         vld_q;
      logic         mode_q;

      // Each node adds RADIX zero-extended children from the previous stage.
      always_comb begin
        for (int n = 0; n < NODES; n++) begin
          sum_d[n] = '0;
          for (int r = 0; r < RADIX; r++) begin
            sum_d[n] = sum_d[n] + W'(g_stage[k-1].stg_data[n*RADIX+r]);
          end
        end
      end

      // Stage register: load data, valid and mode together, or hold on stall.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q  <= 1'b0;
          mode_q <= 1'b0;
          for (int n = 0; n < NODES; n++) begin
            data_q[n] <= '0;
          end
        end else if (adv) begin
          vld_q  <= g_stage[k-1].stg_vld;
          mode_q <= g_stage[k-1].stg_mode;
          for (int n = 0; n < NODES; n++) begin
            data_q[n] <= sum_d[n];
          end
        end
      end

      assign stg_data   = data_q;
      assign stg_vld    = vld_q;
      assign stg_mode   = mode_q;
      assign vld_vec[k] = vld_q;
    end
  end

  assign final_sum = g_stage[LEVELS].stg_data[0];

  // Result formatting from the last stage: mean by dropping the low
  // SHIFT bits, or the sum clamped to all ones when it does not fit.
  always_comb begin
    res_data = '0;
    res_ovf  = 1'b0;
    if (!g_stage[LEVELS].stg_mode) begin
      res_data = final_sum[WF-1:SHIFT];
    end else if (|final_sum[WF-1:ACC_BW]) begin
      res_data = '1;
      res_ovf  = 1'b1;
    end else begin
      res_data = final_sum[ACC_BW-1:0];
    end
  end

  assign bus.out_data  = res_data;
  assign bus.out_ovf   = res_ovf;
  assign bus.out_valid = g_stage[LEVELS].stg_vld;

endmodule
`default_nettype wire
